// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: keeps the in-flight Beq predictions in a FIFO,
// matches each execute-stage resolution against the oldest one, trains the
// predictor, and sequences a flush plus PC redirect on a mispredict.
//
// Handshakes: pred_valid/res_valid are single-cycle qualifiers sampled on the
// rising edge while in RUN; the front end must stall while q_full=1 (a push is
// still taken while full if the same cycle pops on a correct prediction).
// upd_valid is a one-cycle pulse with upd_equal qualified by it.
module branch_resolve_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_alt_pc,
  output logic              q_full,
  input  logic              res_valid,
  input  logic              res_equal,
  output logic              upd_valid,
  output logic              upd_equal,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       mispred_cnt,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int FCW   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic              upd_valid_q, upd_valid_d;
  logic              upd_equal_q, upd_equal_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  // Each entry is {pred_taken, pred_alt_pc}
  logic [ADDR_W:0]   mem_q [DEPTH];
  logic [ADDR_W:0]   head;
  logic              head_taken;
  logic [ADDR_W-1:0] head_alt;

  logic is_run, q_empty, full_int;
  logic resolve, mispred, pop_ok, push;

  assign head       = mem_q[rd_ptr_q];
  assign head_taken = head[ADDR_W];
  assign head_alt   = head[ADDR_W-1:0];

  assign is_run   = (state_q == ST_RUN);
  assign q_empty  = (occ_q == '0);
  assign full_int = (occ_q == OCC_W'(DEPTH));

  // A resolution only counts in RUN against a non-empty queue; a mispredict
  // squashes the queue, so a same-cycle push is never written.
  assign resolve = is_run && res_valid && !q_empty;
  assign mispred = resolve && (head_taken != res_equal);
  assign pop_ok  = resolve && !mispred;
  assign push    = is_run && pred_valid && !mispred && (!full_int || pop_ok);

  assign q_full      = full_int;
  assign upd_valid   = upd_valid_q;
  assign upd_equal   = upd_equal_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign mispred_cnt = cnt_q;
  assign err         = err_q;

  // Next-state, queue bookkeeping and registered outputs
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    fcnt_d      = fcnt_q;
    flush_d     = flush_q;
    redirect_d  = redirect_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    upd_valid_d = resolve;
    upd_equal_d = resolve ? res_equal : 1'b0;

    case (state_q)
      ST_RUN: begin
        if (is_run && pred_valid && full_int && !resolve) err_d = 1'b1;
        if (is_run && res_valid && q_empty)               err_d = 1'b1;
        if (mispred) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          occ_d      = '0;
          redirect_d = head_alt;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          fcnt_d     = FCW'(FLUSH_CYC - 1);
          flush_d    = 1'b1;
          state_d    = ST_FLUSH;
        end else begin
          if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (push && !pop_ok)      occ_d = occ_q + OCC_W'(1);
          else if (!push && pop_ok) occ_d = occ_q - OCC_W'(1);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  // Control and status registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      fcnt_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_equal_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      fcnt_q      <= fcnt_d;
      upd_valid_q <= upd_valid_d;
      upd_equal_q <= upd_equal_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pred_taken, pred_alt_pc};
  end

endmodule
